multi_channel_trigger: RTL and testbench

- Parametrised successor to the single-channel trigger logic.
- Evaluates NUM_CH channels, each with a 5-bit config. Each channel uses its pre-synchronised high and low comparator flops (CHxHff5/CHxLff5).
- Combines the per-channel results in OR or AND mode, and applies a programmable post-arm holdoff.
- Latches a single trigger event with per-channel attribution. Sits between the analog comparator synchronisers and the capture/RAM write controller.

---
 rtl/multi_channel_trigger.sv | 203 ++++++++++++++++++++
 tb/tb_multi_channel_trigger.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_trigger.sv
// multi_channel_trigger: NUM_CH-channel edge/level trigger with OR/AND combine,
// post-arm holdoff and per-channel attribution of the triggering cycle.
// Optional auto-trigger timeout is built when TRIG_AUTO_EN is defined;
// otherwise auto_trig is tied 0 and the block waits in ARMED indefinitely.

// Per-channel hit evaluation (purely combinational).
module mct_channel (
    input  logic [4:0] cfg,
    input  logic       h,
    input  logic       l,
    input  logic       rise,
    input  logic       fall,
    input  logic       pos_seen,
    input  logic       neg_seen,
    output logic       en,
    output logic       hit
);
    // Bit 0 disables the channel; an all-zero condition mask is disabled too.
    assign en  = ~cfg[0] & (|cfg[4:1]);
    assign hit = en & ((cfg[4] & (pos_seen | rise)) |
                       (cfg[3] & (neg_seen | fall)) |
                       (cfg[2] & h) |
                       (cfg[1] & ~l));
endmodule

module multi_channel_trigger #(
    parameter int NUM_CH    = 5,
    parameter int HOLDOFF_W = 8,
    parameter int AUTO_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    CHxHff5,
    input  logic [NUM_CH-1:0]    CHxLff5,
    input  logic [5*NUM_CH-1:0]  trig_cfg,
    input  logic                 combine_and,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 set_armed,
    input  logic                 clr_trig,
    output logic                 armed,
    output logic                 triggered,
    output logic [NUM_CH-1:0]    trig_ch,
    output logic                 auto_trig
);
    typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_ARMED, S_TRIG} state_t;

    if (AUTO_W < 1) begin : g_bad_auto_w
        $error("AUTO_W must be at least 1");
    end

    state_t                state_q, state_d;
    logic [HOLDOFF_W-1:0]  hcnt_q, hcnt_d;
    logic [NUM_CH-1:0]     h_prev_q, l_prev_q;
    logic [NUM_CH-1:0]     pos_seen_q, pos_seen_d;
    logic [NUM_CH-1:0]     neg_seen_q, neg_seen_d;
    logic [NUM_CH-1:0]     trig_ch_q, trig_ch_d;
    logic [NUM_CH-1:0]     rise, fall, ch_en, ch_hit;
    logic                  fire;

    assign rise = CHxHff5 & ~h_prev_q;
    assign fall = ~CHxLff5 & l_prev_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mct_channel u_ch (
            .cfg      (trig_cfg[5*k +: 5]),
            .h        (CHxHff5[k]),
            .l        (CHxLff5[k]),
            .rise     (rise[k]),
            .fall     (fall[k]),
            .pos_seen (pos_seen_q[k]),
            .neg_seen (neg_seen_q[k]),
            .en       (ch_en[k]),
            .hit      (ch_hit[k])
        );
    end

    // Combine enabled channels; with nothing enabled the trigger never fires.
    always_comb begin
        fire = 1'b0;
        if (|ch_en)
            fire = combine_and ? &(ch_hit | ~ch_en) : |ch_hit;
    end

    // Sticky edge flags accumulate only while ARMED, so pre-arm edges never count.
    always_comb begin
        pos_seen_d = '0;
        neg_seen_d = '0;
        if (state_q == S_ARMED) begin
            pos_seen_d = pos_seen_q | rise;
            neg_seen_d = neg_seen_q | fall;
        end
    end

`ifdef TRIG_AUTO_EN
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_trig_q, auto_trig_d;
    assign auto_trig = auto_trig_q;
`else
    assign auto_trig = 1'b0;
`endif

    // Next-state logic; clr_trig overrides everything and returns to IDLE.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        trig_ch_d = trig_ch_q;
`ifdef TRIG_AUTO_EN
        auto_cnt_d  = auto_cnt_q;
        auto_trig_d = auto_trig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (set_armed) begin
                    if (holdoff == '0) begin
                        state_d = S_ARMED;
`ifdef TRIG_AUTO_EN
                        auto_cnt_d = '1;
`endif
                    end else begin
                        state_d = S_HOLDOFF;
                        hcnt_d  = holdoff;
                    end
                end
            end
            S_HOLDOFF: begin
                if (hcnt_q <= HOLDOFF_W'(1)) begin
                    state_d = S_ARMED;
                    hcnt_d  = '0;
`ifdef TRIG_AUTO_EN
                    auto_cnt_d = '1;
`endif
                end else begin
                    hcnt_d = hcnt_q - HOLDOFF_W'(1);
                end
            end
            S_ARMED: begin
`ifdef TRIG_AUTO_EN
                auto_cnt_d = auto_cnt_q - AUTO_W'(1);
`endif
                // A real hit wins over a timeout landing in the same cycle.
                if (fire) begin
                    state_d   = S_TRIG;
                    trig_ch_d = ch_hit;
                end
`ifdef TRIG_AUTO_EN
                else if (auto_cnt_q == AUTO_W'(1)) begin
                    state_d     = S_TRIG;
                    trig_ch_d   = '0;
                    auto_trig_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase
        if (clr_trig) begin
            state_d   = S_IDLE;
            hcnt_d    = '0;
            trig_ch_d = '0;
`ifdef TRIG_AUTO_EN
            auto_trig_d = 1'b0;
`endif
        end
    end

    // State, counters, flags and prev samples; prev samples track every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hcnt_q     <= '0;
            h_prev_q   <= '0;
            l_prev_q   <= '0;
            pos_seen_q <= '0;
            neg_seen_q <= '0;
            trig_ch_q  <= '0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            h_prev_q   <= CHxHff5;
            l_prev_q   <= CHxLff5;
            pos_seen_q <= pos_seen_d;
            neg_seen_q <= neg_seen_d;
            trig_ch_q  <= trig_ch_d;
        end
    end

`ifdef TRIG_AUTO_EN
    // Auto-trigger timeout state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q  <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_trig_q <= auto_trig_d;
        end
    end
`endif

    assign armed     = (state_q == S_ARMED);
    assign triggered = (state_q == S_TRIG);
    assign trig_ch   = trig_ch_q;

endmodule

// File: tb/tb_multi_channel_trigger.sv
// Scoreboard bench for multi_channel_trigger: expected trigger events
// (attribution, auto flag, cycle) are queued when stimulus is driven and
// checked when triggered rises.
module tb_multi_channel_trigger;
    localparam int NUM_CH = 5;
    localparam int HW     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] h = '0;
    logic [NUM_CH-1:0] l = '1;
    logic [5*NUM_CH-1:0] cfg = '0;
    logic              cand = 1'b0;
    logic [HW-1:0]     hold = '0;
    logic              set_armed = 1'b0;
    logic              clr_trig = 1'b0;
    logic              armed, triggered, auto_trig;
    logic [NUM_CH-1:0] trig_ch;

    typedef struct {
        logic [NUM_CH-1:0] ch;
        logic              auto_f;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic trig_prev = 1'b0;

    multi_channel_trigger #(.NUM_CH(NUM_CH), .HOLDOFF_W(HW), .AUTO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .CHxHff5(h), .CHxLff5(l), .trig_cfg(cfg),
        .combine_and(cand), .holdoff(hold), .set_armed(set_armed),
        .clr_trig(clr_trig), .armed(armed), .triggered(triggered),
        .trig_ch(trig_ch), .auto_trig(auto_trig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic all_off();
        for (int k = 0; k < NUM_CH; k++) cfg[5*k +: 5] = 5'b00001;
    endtask

    task automatic push(input logic [NUM_CH-1:0] ch, input logic af, input int c);
        exp_t e;
        e.ch = ch; e.auto_f = af; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_trig(input int limit);
        int n = 0;
        while (!triggered && n < limit) begin
            tick(1);
            n++;
        end
        if (!triggered) chk("trig_timeout", 0, 1);
    endtask

    task automatic arm();
        set_armed = 1'b1;
        tick(1);
        set_armed = 1'b0;
    endtask

    task automatic clear();
        clr_trig = 1'b1;
        tick(1);
        clr_trig = 1'b0;
    endtask

    // Scoreboard monitor: compare each new trigger against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && triggered && !trig_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_trig", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("trig_ch", 32'(trig_ch), 32'(e.ch));
                chk("auto_trig", 32'(auto_trig), 32'(e.auto_f));
                chk("trig_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        trig_prev = triggered;
    end

    initial begin
        int k0;
        all_off();
        tick(3);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_trig", 32'(triggered), 0);
        chk("rst_trig_ch", 32'(trig_ch), 0);
        chk("rst_auto", 32'(auto_trig), 0);
        rst_n = 1'b1;
        tick(2);

        // Level trigger, OR mode, holdoff 0
        cfg[10 +: 5] = 5'b00100;
        arm();
        chk("t1_armed", 32'(armed), 1);
        tick(2);
        chk("t1_no_trig", 32'(triggered), 0);
        h[2] = 1'b1;
        push(5'b00100, 1'b0, cyc + 1);
        wait_trig(10);
        chk("t1_armed_low", 32'(armed), 0);
        // clr_trig together with set_armed: clear wins, arm ignored
        set_armed = 1'b1;
        clear();
        set_armed = 1'b0;
        chk("clr_trig", 32'(triggered), 0);
        chk("clr_armed", 32'(armed), 0);
        chk("clr_ch", 32'(trig_ch), 0);
        h[2] = 1'b0;
        tick(1);
        chk("clr_idle", 32'(armed), 0);

        // Edge trigger with holdoff 4; edge during HOLDOFF ignored
        all_off();
        cfg[0 +: 5] = 5'b10000;
        hold = 8'd4;
        arm();
        chk("t2_hold0", 32'(armed), 0);
        tick(1);
        h[0] = 1'b1;
        tick(1);
        h[0] = 1'b0;
        tick(1);
        chk("t2_hold3", 32'(armed), 0);
        tick(1);
        chk("t2_armed", 32'(armed), 1);
        tick(2);
        chk("t2_early_ignored", 32'(triggered), 0);
        h[0] = 1'b1;
        push(5'b00001, 1'b0, cyc + 1);
        wait_trig(10);
        clear();
        h[0] = 1'b0;
        hold = '0;

        // AND mode with sticky positive-edge flag
        all_off();
        cfg[0 +: 5] = 5'b10000;
        cfg[5 +: 5] = 5'b00010;
        cand = 1'b1;
        arm();
        h[0] = 1'b1;
        tick(1);
        h[0] = 1'b0;
        tick(3);
        chk("t3_and_partial", 32'(triggered), 0);
        l[1] = 1'b0;
        push(5'b00011, 1'b0, cyc + 1);
        wait_trig(10);
        clear();
        l[1] = 1'b1;
        cand = 1'b0;

        // All channels disabled, both combine modes, inputs active
        all_off();
        for (int m = 0; m < 2; m++) begin
            cand = m[0];
            h = '1;
            l = '0;
            k0 = cyc;
            arm();
`ifdef TRIG_AUTO_EN
            push('0, 1'b1, k0 + 16);
            wait_trig(40);
            chk("t4_auto_armed_cycles", 32'(cyc - k0 - 1), 15);
`else
            tick(1000);
            chk("t4_never", 32'(triggered), 0);
            chk("t4_still_armed", 32'(armed), 1);
`endif
            clear();
            h = '0;
            l = '1;
            tick(1);
        end
        cand = 1'b0;

`ifdef TRIG_AUTO_EN
        // Real hit on the timeout cycle wins over auto
        cfg[10 +: 5] = 5'b00100;
        arm();
        tick(14);
        h[2] = 1'b1;
        push(5'b00100, 1'b0, cyc + 1);
        wait_trig(5);
        clear();
        h[2] = 1'b0;
        all_off();
`endif

        // Asynchronous reset while ARMED
        cfg[0 +: 5] = 5'b10000;
        arm();
        chk("t5_armed", 32'(armed), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_armed", 32'(armed), 0);
        chk("t5_async_trig", 32'(triggered), 0);
        tick(2);
        rst_n = 1'b1;
        h[0] = 1'b1;
        tick(5);
        chk("t5_post_rst_trig", 32'(triggered), 0);
        chk("t5_post_rst_armed", 32'(armed), 0);
        h[0] = 1'b0;

        tick(2);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
